// File: rtl/mem_access_unit.sv
// Load/store initiator for the big-endian byte-addressed data memory: sub-word load
// extraction with sign/zero extension and read-modify-write for byte/halfword stores.
module mem_access_unit #(
   parameter int READ_LATENCY = 1,
   parameter int MEM_BYTES    = 2000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic [2:0]  Op,
   input  logic [31:0] Addr,
   input  logic [31:0] Store_data,
   output logic [31:0] Load_data,
   output logic        Busy,
   output logic        Done,
   output logic        Err,
   output logic [31:0] Mem_address,
   output logic [31:0] Mem_write_data,
   output logic        Mem_read,
   output logic        Mem_write,
   input  logic [31:0] Mem_read_data,
   output logic [2:0]  o_dbg_state
);

   // Handshake: Req is sampled only while idle (Busy=0); a request is complete on the
   // single cycle where Done=1, with Err qualifying it. Req during Busy is dropped.

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_SW  = 3'b010;
   localparam logic [2:0] OP_LW  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_SH  = 3'b111;

   localparam logic [7:0]  CNT_LAST  = 8'(READ_LATENCY);
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_op;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_load_data;
   logic [7:0]  r_cnt;

   logic        w_misalign;
   logic        w_range_err;
   logic        w_req_err;
   logic        w_rd_last;
   logic        w_is_store;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   always_comb begin
      w_misalign  = (((Op == OP_LH) || (Op == OP_LHU) || (Op == OP_SH)) && Addr[0]) ||
                    (((Op == OP_LW) || (Op == OP_SW)) && (Addr[1:0] != 2'b00));
      // Any access whose containing word runs past the end of memory is rejected.
      w_range_err = {Addr[31:2], 2'b11} >= MEM_LIMIT;
      w_req_err   = w_misalign || w_range_err;
      w_rd_last   = (r_cnt == CNT_LAST);
      w_is_store  = (r_op == OP_SB) || (r_op == OP_SH);
   end

   always_comb begin
      w_byte = 8'h00;
      case (r_addr[1:0])
         2'd0:    w_byte = Mem_read_data[31:24];
         2'd1:    w_byte = Mem_read_data[23:16];
         2'd2:    w_byte = Mem_read_data[15:8];
         default: w_byte = Mem_read_data[7:0];
      endcase
      w_half = r_addr[1] ? Mem_read_data[15:0] : Mem_read_data[31:16];

      w_load = Mem_read_data;
      case (r_op)
         OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_load = {24'h0, w_byte};
         OP_LH:   w_load = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_load = {16'h0, w_half};
         default: w_load = Mem_read_data;
      endcase

      w_merge = Mem_read_data;
      if (r_op == OP_SB) begin
         case (r_addr[1:0])
            2'd0:    w_merge[31:24] = r_wdata[7:0];
            2'd1:    w_merge[23:16] = r_wdata[7:0];
            2'd2:    w_merge[15:8]  = r_wdata[7:0];
            default: w_merge[7:0]   = r_wdata[7:0];
         endcase
      end else if (r_addr[1]) begin
         w_merge[15:0] = r_wdata[15:0];
      end else begin
         w_merge[31:16] = r_wdata[15:0];
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (Req) begin
               if (w_req_err)        w_next = S_ERR;
               else if (Op == OP_SW) w_next = S_WR;
               else                  w_next = S_RD;
            end
         end
         S_RD: begin
            if (w_rd_last) w_next = w_is_store ? S_WR : S_DONE;
         end
         S_WR:    w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_op        <= 3'b000;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_load_data <= 32'h0;
         r_cnt       <= 8'h0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (Req) begin
                  r_op    <= Op;
                  r_addr  <= Addr;
                  r_wdata <= Store_data;
                  r_cnt   <= 8'h0;
               end
            end
            S_RD: begin
               if (w_rd_last) begin
                  if (w_is_store) r_wdata     <= w_merge;
                  else            r_load_data <= w_load;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      Load_data      = r_load_data;
      Busy           = (r_state != S_IDLE);
      Done           = (r_state == S_DONE) || (r_state == S_ERR);
      Err            = (r_state == S_ERR);
      Mem_read       = (r_state == S_RD);
      Mem_write      = (r_state == S_WR);
      Mem_address    = 32'h0;
      Mem_write_data = 32'h0;
      if ((r_state == S_RD) || (r_state == S_WR)) Mem_address = {r_addr[31:2], 2'b00};
      if (r_state == S_WR) Mem_write_data = r_wdata;
      o_dbg_state    = r_state;
   end

endmodule
